// File: rtl/master_decoder.sv
// AHB master-side address decoder, data-phase select register and default slave.
// Optional error counter output o_err_count is enabled by defining DECODER_ERR_CNT_EN.
module master_decoder #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int REGION_LSB = 28
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic [NUM_SLAVES-1:0] i_shreadyout,
  output logic [NUM_SLAVES-1:0] o_hsel_addr,
  output logic [NUM_SLAVES-1:0] o_hsel_data,
  output logic                  o_mhready,
  output logic                  o_dflt_hresp
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [15:0]           o_err_count
`endif
);

  localparam int RW = ADDR_WIDTH - REGION_LSB;

  typedef enum logic [1:0] {
    DF_IDLE = 2'd0,
    DF_ERR1 = 2'd1,
    DF_ERR2 = 2'd2
  } df_state_t;

  df_state_t             r_state;
  df_state_t             w_state_nxt;
  logic [NUM_SLAVES-1:0] r_hsel_data;
  logic                  r_dflt_sel;
  logic [RW-1:0]         w_region;
  logic [31:0]           w_region_ext;
  logic                  w_unmapped;
  logic                  w_dflt_ready;
  logic                  w_err_start;
  logic                  w_unused;

  assign w_region     = i_haddr[ADDR_WIDTH-1:REGION_LSB];
  assign w_region_ext = 32'(w_region);
  assign w_unmapped   = (w_region_ext >= 32'(NUM_SLAVES));
  assign w_unused     = ^{i_htrans[0], i_haddr[REGION_LSB-1:0]};

  always_comb begin
    o_hsel_addr = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_hsel_addr[i] = (w_region_ext == 32'(i));
    end
  end

  // Default slave only inserts a wait in the first ERROR cycle.
  assign w_dflt_ready = (r_state != DF_ERR1);
  assign o_dflt_hresp = (r_state != DF_IDLE);

  always_comb begin
    if (|r_hsel_data) begin
      o_mhready = |(r_hsel_data & i_shreadyout);
    end else if (r_dflt_sel) begin
      o_mhready = w_dflt_ready;
    end else begin
      o_mhready = 1'b1;
    end
  end

  assign w_err_start = o_mhready && w_unmapped && i_htrans[1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DF_IDLE: if (w_err_start) w_state_nxt = DF_ERR1;
      DF_ERR1: w_state_nxt = DF_ERR2;
      DF_ERR2: w_state_nxt = w_err_start ? DF_ERR1 : DF_IDLE;
      default: w_state_nxt = DF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= DF_IDLE;
      r_hsel_data <= '0;
      r_dflt_sel  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (o_mhready) begin
        r_hsel_data <= o_hsel_addr;
        r_dflt_sel  <= w_unmapped;
      end
    end
  end

  assign o_hsel_data = r_hsel_data;

`ifdef DECODER_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Every transition into DF_ERR1 is a fresh error, since DF_ERR1 never loops on itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_count <= 16'd0;
    end else if ((w_state_nxt == DF_ERR1) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_master_decoder.sv
// Self-checking bench for master_decoder: decode vector table with a data-phase
// scoreboard, plus wait-state, back-to-back error and reset-abort sequences.
module tb_master_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [1:0]  shready;
  logic [1:0]  hsel_addr;
  logic [1:0]  hsel_data;
  logic        mhready;
  logic        dflt_hresp;
`ifdef DECODER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [1:0]  exp_hsel;
    bit          exp_err;
  } vec_t;

  vec_t       vecs[9];
  logic [1:0] sb_q[$];

  master_decoder #(.NUM_SLAVES(2), .ADDR_WIDTH(32), .REGION_LSB(28)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_haddr      (haddr),
    .i_htrans     (htrans),
    .i_shreadyout (shready),
    .o_hsel_addr  (hsel_addr),
    .o_hsel_data  (hsel_data),
    .o_mhready    (mhready),
    .o_dflt_hresp (dflt_hresp)
`ifdef DECODER_ERR_CNT_EN
    ,
    .o_err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string nm);
`ifdef DECODER_ERR_CNT_EN
    check(nm, int'(err_count), m_cnt);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  initial begin
    vecs[0] = '{32'h1000_0040, T_NSEQ, 2'b10, 1'b0};
    vecs[1] = '{32'h0000_1234, T_SEQ,  2'b01, 1'b0};
    vecs[2] = '{32'h3000_0000, T_NSEQ, 2'b00, 1'b1};
    vecs[3] = '{32'hF000_0000, T_IDLE, 2'b00, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, T_SEQ,  2'b00, 1'b1};
    vecs[5] = '{32'h2000_0000, T_BUSY, 2'b00, 1'b0};
    vecs[6] = '{32'h0FFF_FFFF, T_NSEQ, 2'b01, 1'b0};
    vecs[7] = '{32'h1FFF_FFFC, T_IDLE, 2'b10, 1'b0};
    vecs[8] = '{32'h2000_0000, T_SEQ,  2'b00, 1'b1};

    rst = 1'b1; haddr = 32'h0; htrans = T_IDLE; shready = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_hsel_data", int'(hsel_data), 0);
    check("rst_mhready", int'(mhready), 1);
    check("rst_hresp", int'(dflt_hresp), 0);
    check_cnt("rst_err_count");

    for (int v = 0; v < 9; v++) begin
      haddr = vecs[v].haddr; htrans = vecs[v].htrans; shready = 2'b11;
      #1;
      check("hsel_addr", int'(hsel_addr), int'(vecs[v].exp_hsel));
      check("accept_rdy", int'(mhready), 1);
      sb_q.push_back(vecs[v].exp_hsel);
      if (vecs[v].exp_err) m_cnt++;
      tick();
      haddr = 32'h0; htrans = T_IDLE;
      #1;
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got no entry want one");
      end else begin
        check("hsel_data", int'(hsel_data), int'(sb_q.pop_front()));
      end
      if (vecs[v].exp_err) begin
        check("err1_rdy", int'(mhready), 0);
        check("err1_resp", int'(dflt_hresp), 1);
        tick();
        check("err2_rdy", int'(mhready), 1);
        check("err2_resp", int'(dflt_hresp), 1);
        tick();
        check("err_done_resp", int'(dflt_hresp), 0);
        check("err_done_rdy", int'(mhready), 1);
      end else begin
        check("dp_rdy", int'(mhready), 1);
        check("dp_resp", int'(dflt_hresp), 0);
      end
      check_cnt("vec_err_count");
      tick();
    end

    // Slave 0 inserts three wait states; the pending slave-1 address must not be captured.
    haddr = 32'h0; htrans = T_NSEQ; shready = 2'b11;
    tick();
    shready = 2'b10; haddr = 32'h1000_0000; htrans = T_NSEQ;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_rdy", int'(mhready), 0);
      check("wait_hold", int'(hsel_data), 1);
      tick();
    end
    shready = 2'b11;
    #1;
    check("wait_done_rdy", int'(mhready), 1);
    check("wait_done_hold", int'(hsel_data), 1);
    tick();
    check("wait_next_sel", int'(hsel_data), 2);
    haddr = 32'h0; htrans = T_IDLE;
    tick();

    // Back-to-back unmapped NONSEQ: the second error is accepted during DF_ERR2.
    haddr = 32'h3000_0000; htrans = T_NSEQ;
    m_cnt++;
    tick();
    check("b2b_err1_rdy", int'(mhready), 0);
    tick();
    check("b2b_err2_rdy", int'(mhready), 1);
    check("b2b_err2_resp", int'(dflt_hresp), 1);
    m_cnt++;
    tick();
    htrans = T_IDLE;
    #1;
    check("b2b_again_rdy", int'(mhready), 0);
    check("b2b_again_resp", int'(dflt_hresp), 1);
    check_cnt("b2b_err_count");
    tick();
    tick();
    check("b2b_idle_resp", int'(dflt_hresp), 0);

    // Reset sampled during DF_ERR1 aborts the error with no trailing ERROR cycle.
    haddr = 32'h3000_0000; htrans = T_NSEQ;
    tick();
    check("rerr_err1_resp", int'(dflt_hresp), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; htrans = T_IDLE;
    m_cnt = 0;
    #1;
    check("rerr_rdy", int'(mhready), 1);
    check("rerr_resp", int'(dflt_hresp), 0);
    check("rerr_hsel_data", int'(hsel_data), 0);
    check_cnt("rerr_err_count");
    tick();
    check("rerr_next_resp", int'(dflt_hresp), 0);
    check("rerr_next_rdy", int'(mhready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
